// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel key debouncer.
package key_debounce_pkg;

   localparam int DCNT_W = 8;

   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_PRESSED  = 2'd1,
      ST_LONG     = 2'd2
   } key_state_e;

   // Hold counter must represent the larger of the long-press and repeat thresholds.
   function automatic int hcnt_width(input int long_ms, input int repeat_ms);
      int max_ms;
      max_ms = (long_ms > repeat_ms) ? long_ms : repeat_ms;
      return (max_ms < 1) ? 1 : $clog2(max_ms + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, tick-based debounce and the press/long/repeat event FSM.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_MS = 10,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200,
   parameter int REPEAT_EN   = 1,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic key_in,
   output logic key_level,
   output logic key_pressed,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat
);

   localparam int                HCNT_W      = hcnt_width(LONG_MS, REPEAT_MS);
   localparam logic              IDLE_LEVEL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_MS - 1);
   localparam logic [HCNT_W-1:0] LONG_LAST   = HCNT_W'(LONG_MS - 1);
   localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_MS - 1);

   logic              sync1_r;
   logic              sync2_r;
   logic [DCNT_W-1:0] dcnt_r;
   logic [HCNT_W-1:0] hcnt_r;
   key_state_e        state_r;
   logic              accept_s;
   logic              accept_press_s;
   logic              accept_release_s;

   // Acceptance happens on the tick that would bring the mismatch count to DEBOUNCE_MS.
   always_comb begin
      accept_s = 1'b0;
      if ((sync2_r != key_level) && tick && (dcnt_r == DCNT_LAST)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      accept_press_s   = accept_s && (sync2_r != IDLE_LEVEL);
      accept_release_s = accept_s && (sync2_r == IDLE_LEVEL);
   end

   // Synchroniser and debounce counter; any return to the stable level discards progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r   <= IDLE_LEVEL;
         sync2_r   <= IDLE_LEVEL;
         dcnt_r    <= '0;
         key_level <= IDLE_LEVEL;
      end else begin
         sync1_r <= key_in;
         sync2_r <= sync1_r;
         if (sync2_r == key_level) begin
            dcnt_r <= '0;
         end else if (accept_s) begin
            key_level <= sync2_r;
            dcnt_r    <= '0;
         end else if (tick) begin
            dcnt_r <= dcnt_r + DCNT_W'(1);
         end
      end
   end

   // Event FSM; a release accepted on a threshold tick wins over long/repeat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_RELEASED;
         hcnt_r      <= '0;
         key_pressed <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
         case (state_r)
            ST_RELEASED: begin
               if (accept_press_s) begin
                  state_r     <= ST_PRESSED;
                  hcnt_r      <= '0;
                  key_pressed <= 1'b1;
                  key_press   <= 1'b1;
               end
            end
            ST_PRESSED: begin
               if (accept_release_s) begin
                  state_r     <= ST_RELEASED;
                  hcnt_r      <= '0;
                  key_pressed <= 1'b0;
                  key_release <= 1'b1;
               end else if (tick) begin
                  if (hcnt_r == LONG_LAST) begin
                     state_r  <= ST_LONG;
                     hcnt_r   <= '0;
                     key_long <= 1'b1;
                  end else begin
                     hcnt_r <= hcnt_r + HCNT_W'(1);
                  end
               end
            end
            ST_LONG: begin
               if (accept_release_s) begin
                  state_r     <= ST_RELEASED;
                  hcnt_r      <= '0;
                  key_pressed <= 1'b0;
                  key_release <= 1'b1;
               end else if ((REPEAT_EN != 0) && tick) begin
                  if (hcnt_r == REPEAT_LAST) begin
                     hcnt_r     <= '0;
                     key_repeat <= 1'b1;
                  end else begin
                     hcnt_r <= hcnt_r + HCNT_W'(1);
                  end
               end
            end
            default: begin
               state_r     <= ST_RELEASED;
               hcnt_r      <= '0;
               key_pressed <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debounce_array.sv
// NUM_KEYS debounced key channels sharing one free-running millisecond tick.
module key_debounce_array
   import key_debounce_pkg::*;
#(
   parameter int NUM_KEYS     = 4,
   parameter int CLK_FREQ_KHZ = 100000,
   parameter int DEBOUNCE_MS  = 10,
   parameter int LONG_MS      = 1000,
   parameter int REPEAT_MS    = 200,
   parameter int REPEAT_EN    = 1,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat
);

   localparam int               PRE_W    = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_KHZ - 1);

   logic [PRE_W-1:0] pre_cnt_r;
   logic             tick_s;

   assign tick_s = (pre_cnt_r == PRE_LAST);

   // Free-running prescaler; only reset may realign the tick phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_r <= '0;
      end else if (tick_s) begin
         pre_cnt_r <= '0;
      end else begin
         pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .LONG_MS     (LONG_MS),
         .REPEAT_MS   (REPEAT_MS),
         .REPEAT_EN   (REPEAT_EN),
         .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick        (tick_s),
         .key_in      (key_in[i]),
         .key_level   (key_level[i]),
         .key_pressed (key_pressed[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i]),
         .key_repeat  (key_repeat[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: timing-arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_key_debounce_array;

   localparam int NK    = 4;
   localparam int CLKK  = 10;
   localparam int DEB   = 3;
   localparam int LONGT = 5;
   localparam int REPT  = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key_in = 4'hF;

   logic [NK-1:0] lvl_a, prs_a, press_a, rel_a, long_a, rep_a;
   logic [NK-1:0] lvl_b, prs_b, press_b, rel_b, long_b, rep_b;

   always #5 clk = ~clk;

   key_debounce_array #(
      .NUM_KEYS(NK), .CLK_FREQ_KHZ(CLKK), .DEBOUNCE_MS(DEB), .LONG_MS(LONGT),
      .REPEAT_MS(REPT), .REPEAT_EN(1), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(lvl_a), .key_pressed(prs_a),
      .key_press(press_a), .key_release(rel_a), .key_long(long_a), .key_repeat(rep_a)
   );

   key_debounce_array #(
      .NUM_KEYS(NK), .CLK_FREQ_KHZ(CLKK), .DEBOUNCE_MS(DEB), .LONG_MS(LONGT),
      .REPEAT_MS(REPT), .REPEAT_EN(0), .ACTIVE_LOW(1)
   ) dut_norep (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(lvl_b), .key_pressed(prs_b),
      .key_press(press_b), .key_release(rel_b), .key_long(long_b), .key_repeat(rep_b)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_v(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (cycle/tick arithmetic) ----------------
   int            cyc = 0;
   bit            model_ready = 1'b0;
   logic [NK-1:0] m_s1, m_s2, m_lvl, m_prs;
   int            m_run[NK];
   int            m_pt[NK];
   int            m_lt[NK];
   logic [NK-1:0] exp_lvl, exp_press, exp_rel, exp_long, exp_rep;

   task automatic model_step();
      if (!rst_n) begin
         m_s1 = '1; m_s2 = '1; m_lvl = '1; m_prs = '0;
         for (int ch = 0; ch < NK; ch++) begin
            m_run[ch] = -1; m_pt[ch] = 0; m_lt[ch] = -1;
         end
         exp_lvl = '1; exp_press = '0; exp_rel = '0; exp_long = '0; exp_rep = '0;
         cyc = 0;
         model_ready = 1'b1;
      end else begin
         exp_press = '0; exp_rel = '0; exp_long = '0; exp_rep = '0;
         for (int ch = 0; ch < NK; ch++) begin
            logic acc;
            acc = 1'b0;
            if (m_s2[ch] != m_lvl[ch]) begin
               if (m_run[ch] < 0) m_run[ch] = cyc;
               // ticks fall on cycles c with c%CLKK==CLKK-1; count those inside [run start, now]
               if ((cyc % CLKK == CLKK - 1) && ((cyc + 1) / CLKK - m_run[ch] / CLKK == DEB))
                  acc = 1'b1;
            end else begin
               m_run[ch] = -1;
            end
            if (acc) begin
               m_lvl[ch] = m_s2[ch];
               m_run[ch] = -1;
               if (m_s2[ch] == 1'b0) begin
                  exp_press[ch] = 1'b1; m_prs[ch] = 1'b1; m_pt[ch] = cyc; m_lt[ch] = -1;
               end else begin
                  exp_rel[ch] = 1'b1; m_prs[ch] = 1'b0;
               end
            end else if (m_prs[ch]) begin
               if (m_lt[ch] < 0) begin
                  if (cyc == m_pt[ch] + CLKK * LONGT) begin
                     exp_long[ch] = 1'b1; m_lt[ch] = cyc;
                  end
               end else if ((cyc - m_lt[ch]) % (CLKK * REPT) == 0) begin
                  exp_rep[ch] = 1'b1;
               end
            end
         end
         exp_lvl = m_lvl;
         m_s2 = m_s1;
         m_s1 = key_in;
         cyc++;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- monitor of DUT events for hand-computed checks ----------------
   int            p_cnt[NK], r_cnt[NK], l_cnt[NK], rp_cnt[NK], lb_cnt[NK], rpb_cnt[NK];
   int            p_at[NK], r_at[NK], l_at[NK], rp_first[NK], rp_last[NK];
   logic [NK-1:0] long_snap[NK];
   bit            saw_1001;

   task automatic clr();
      for (int ch = 0; ch < NK; ch++) begin
         p_cnt[ch] = 0; r_cnt[ch] = 0; l_cnt[ch] = 0; rp_cnt[ch] = 0; lb_cnt[ch] = 0; rpb_cnt[ch] = 0;
         p_at[ch] = -1000; r_at[ch] = -1000; l_at[ch] = -1000; rp_first[ch] = -1000; rp_last[ch] = -1000;
         long_snap[ch] = '1;
      end
      saw_1001 = 1'b0;
   endtask

   task automatic monitor();
      int e;
      e = cyc - 1;
      for (int ch = 0; ch < NK; ch++) begin
         if (press_a[ch]) begin p_cnt[ch]++; p_at[ch] = e; end
         if (rel_a[ch])   begin r_cnt[ch]++; r_at[ch] = e; long_snap[ch] = long_a; end
         if (long_a[ch])  begin l_cnt[ch]++; l_at[ch] = e; end
         if (rep_a[ch]) begin
            if (rp_cnt[ch] == 0) rp_first[ch] = e;
            rp_cnt[ch]++; rp_last[ch] = e;
         end
         if (long_b[ch]) lb_cnt[ch]++;
         if (rep_b[ch])  rpb_cnt[ch]++;
      end
      if (press_a == 4'b1001) saw_1001 = 1'b1;
   endtask

   initial forever begin
      @(negedge clk);
      if (model_ready) begin
         check_v("outputs_repeat_en", {lvl_a, prs_a, press_a, rel_a, long_a, rep_a},
                 {exp_lvl, ~exp_lvl, exp_press, exp_rel, exp_long, exp_rep});
         check_v("outputs_repeat_dis", {lvl_b, prs_b, press_b, rel_b, long_b, rep_b},
                 {exp_lvl, ~exp_lvl, exp_press, exp_rel, exp_long, 4'h0});
         if (rst_n) monitor();
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int t;
      int n0;
      int hold[NK];
      clr();

      // reset state, inputs toggling while held in reset
      rst_n = 1'b0; key_in = 4'hF;
      step(3);
      check_v("reset_idle", {lvl_a, prs_a, press_a, rel_a, long_a, rep_a}, {4'hF, 20'h0});
      for (int i = 0; i < 5; i++) begin
         key_in = 4'($urandom);
         step(1);
         check_v("reset_hold", {lvl_a, prs_a, press_a, rel_a, long_a, rep_a}, {4'hF, 20'h0});
      end
      key_in = 4'hF;
      step(1);
      rst_n = 1'b1;
      step(30);
      check_i("post_reset_level", int'(lvl_a), 15);

      // glitch of 15 cycles is rejected
      clr();
      key_in[0] = 1'b0; step(15); key_in[0] = 1'b1; step(60);
      check_i("glitch_no_press", p_cnt[0], 0);
      check_i("glitch_level", int'(lvl_a[0]), 1);

      // short press on key 1
      clr();
      key_in[1] = 1'b0; k = cyc;
      t = 0;
      while (p_cnt[1] == 0 && t < 60) begin step(1); t++; end
      check_i("press_latency_21_31", int'((p_at[1] - k >= 21) && (p_at[1] - k <= 31)), 1);
      step(20);
      key_in[1] = 1'b1;
      step(60);
      check_i("short_press_count", p_cnt[1], 1);
      check_i("short_release_count", r_cnt[1], 1);
      check_i("short_no_long", l_cnt[1], 0);

      // long press with auto-repeat on key 2
      clr();
      key_in[2] = 1'b0; step(200); key_in[2] = 1'b1;
      t = 0;
      while (r_cnt[2] == 0 && t < 60) begin step(1); t++; end
      n0 = rp_cnt[2];
      step(60);
      check_i("long_after_press", l_at[2] - p_at[2], 50);
      check_i("first_repeat_gap", rp_first[2] - l_at[2], 20);
      check_i("repeat_period", rp_last[2] - rp_first[2], 20 * (rp_cnt[2] - 1));
      check_i("repeat_count", rp_cnt[2], 7);
      check_i("release_after_press", r_at[2] - p_at[2], 200);
      check_i("repeats_stop", rp_cnt[2], n0);
      check_i("norep_long_count", lb_cnt[2], 1);
      check_i("norep_repeat_count", rpb_cnt[2], 0);

      // simultaneous presses; release of key 3 lands on its long threshold tick
      clr();
      key_in[0] = 1'b0; key_in[3] = 1'b0;
      t = 0;
      while (p_cnt[3] == 0 && t < 60) begin step(1); t++; end
      check_i("dual_press_same_cycle", int'(saw_1001), 1);
      t = 0;
      while (cyc < p_at[3] + 25 && t < 100) begin step(1); t++; end
      key_in[3] = 1'b1;
      step(60);
      check_i("coincide_release", r_cnt[3], 1);
      check_i("coincide_no_long", l_cnt[3], 0);
      check_i("coincide_release_time", r_at[3] - p_at[3], 50);
      check_i("coincide_long_vector", int'(long_snap[3]), 1);
      check_i("ch0_long_unaffected", l_cnt[0], 1);
      check_i("ch0_no_release", r_cnt[0], 0);
      key_in[0] = 1'b1;
      step(60);

      // randomized hold/glitch traffic on all keys
      for (int ch = 0; ch < NK; ch++) hold[ch] = int'($urandom_range(1, 60));
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < NK; ch++) begin
            if (hold[ch] == 0) begin
               key_in[ch] = ~key_in[ch];
               hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25))
                                                      : int'($urandom_range(20, 180));
            end else begin
               hold[ch]--;
            end
         end
         step(1);
      end
      key_in = 4'hF;
      step(60);

      // reset asserted mid-press emits no release
      clr();
      key_in[1] = 1'b0;
      t = 0;
      while (p_cnt[1] == 0 && t < 60) begin step(1); t++; end
      step(10);
      rst_n = 1'b0;
      step(1);
      check_v("mid_press_reset", {lvl_a, prs_a, press_a, rel_a, long_a, rep_a}, {4'hF, 20'h0});
      key_in = 4'hF;
      step(3);
      rst_n = 1'b1;
      step(40);
      check_i("no_release_after_reset", r_cnt[1], 0);
      check_i("level_after_reset", int'(lvl_a), 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
